// File: rtl/pmem_ld_pkg.sv
// pmem_ld_pkg: shared widths and FSM state encoding for the program-memory loader.
// The CHK state only exists when PMEM_LOAD_CHECKSUM_EN is defined.
package pmem_ld_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned INSTR_W = 12;
   localparam int unsigned HI_W    = INSTR_W - BYTE_W;
   localparam int unsigned HOLD_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_LO   = 3'd2,
      S_HI   = 3'd3,
      S_WR   = 3'd4,
      S_HOLD = 3'd5,
`ifdef PMEM_LOAD_CHECKSUM_EN
      S_CHK  = 3'd7,
`endif
      S_RUN  = 3'd6
   } state_e;

endpackage

// File: rtl/pmem_ld_csum.sv
// pmem_ld_csum: 8-bit modulo-256 running sum with clear, plus compare of the
// incoming byte against the accumulated sum.
// Ports: clk, rst (async, active-high), clr_i (zero the sum), acc_i (add din_i),
//        din_i (stream byte), match_c (combinational: sum == din_i).
module pmem_ld_csum
   import pmem_ld_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              acc_i,
   input  logic [BYTE_W-1:0] din_i,
   output logic              match_c
);

   logic [BYTE_W-1:0] sum_q;

   // Running sum; clear wins over accumulate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
      end else if (clr_i) begin
         sum_q <= '0;
      end else if (acc_i) begin
         sum_q <= sum_q + din_i;
      end
   end

   assign match_c = (sum_q == din_i);

endmodule

// File: rtl/pmem_load_ctrl.sv
// pmem_load_ctrl: loads program memory from a byte stream (length byte, then
// lo/hi byte pairs per 12-bit instruction), then holds the CPU for RELEASE_DLY
// cycles before releasing it. Define PMEM_LOAD_CHECKSUM_EN to require a trailing
// checksum byte (sum mod 256 of all previous bytes) before release.
// Ports: clk, rst (async, active-high), start, in_valid/in_data/in_ready (byte
//        stream), LEnable/LAddress/LI_port (memory write), cpu_run, busy,
//        done (1-cycle pulse on release), err (sticky checksum error).
module pmem_load_ctrl
   import pmem_ld_pkg::*;
#(
   parameter int unsigned RELEASE_DLY = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               in_valid,
   input  logic [BYTE_W-1:0]  in_data,
   output logic               in_ready,
   output logic               LEnable,
   output logic [ADDR_W-1:0]  LAddress,
   output logic [INSTR_W-1:0] LI_port,
   output logic               cpu_run,
   output logic               busy,
   output logic               done,
   output logic               err
);

   state_e               state_q;
   logic                 in_ready_q;
   logic                 len_q;
   logic                 cpu_run_q;
   logic                 busy_q;
   logic                 done_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [ADDR_W-1:0]    laddr_q;
   logic [BYTE_W-1:0]    cnt_q;
   logic [BYTE_W-1:0]    lo_q;
   logic [INSTR_W-1:0]   li_q;
   logic [HOLD_W-1:0]    hold_q;
   logic                 hs_c;
   logic                 restart_c;

   assign hs_c      = in_valid && in_ready_q;
   assign restart_c = start && ((state_q == S_IDLE) || (state_q == S_RUN));

`ifdef PMEM_LOAD_CHECKSUM_EN
   logic err_q;
   logic csum_acc_c;
   logic csum_match_c;

   // Length and every lo/hi byte feed the checksum; the checksum byte itself does not.
   assign csum_acc_c = hs_c && ((state_q == S_LEN) || (state_q == S_LO) || (state_q == S_HI));

   pmem_ld_csum u_csum (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (restart_c),
      .acc_i   (csum_acc_c),
      .din_i   (in_data),
      .match_c (csum_match_c)
   );

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Load sequencer; every output is updated on the transition that enters its state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         in_ready_q <= 1'b0;
         len_q      <= 1'b0;
         cpu_run_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         addr_q     <= '0;
         laddr_q    <= '0;
         cnt_q      <= '0;
         lo_q       <= '0;
         li_q       <= '0;
         hold_q     <= '0;
`ifdef PMEM_LOAD_CHECKSUM_EN
         err_q      <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         len_q  <= 1'b0;
         case (state_q)
            S_IDLE, S_RUN: begin
               if (restart_c) begin
                  state_q    <= S_LEN;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  cpu_run_q  <= 1'b0;
                  addr_q     <= '0;
`ifdef PMEM_LOAD_CHECKSUM_EN
                  err_q      <= 1'b0;
`endif
               end
            end
            S_LEN: begin
               if (hs_c) begin
                  cnt_q   <= in_data;
                  state_q <= S_LO;
               end
            end
            S_LO: begin
               if (hs_c) begin
                  lo_q    <= in_data;
                  state_q <= S_HI;
               end
            end
            S_HI: begin
               // Upper nibble of the hi byte is dropped from the instruction word.
               if (hs_c) begin
                  state_q    <= S_WR;
                  in_ready_q <= 1'b0;
                  len_q      <= 1'b1;
                  laddr_q    <= addr_q;
                  li_q       <= {in_data[HI_W-1:0], lo_q};
               end
            end
            S_WR: begin
               // cnt holds instructions remaining minus one, so zero marks the last write.
               if (cnt_q == '0) begin
`ifdef PMEM_LOAD_CHECKSUM_EN
                  state_q    <= S_CHK;
                  in_ready_q <= 1'b1;
`else
                  state_q    <= S_HOLD;
                  hold_q     <= HOLD_W'(RELEASE_DLY);
`endif
               end else begin
                  addr_q     <= addr_q + ADDR_W'(1);
                  cnt_q      <= cnt_q - BYTE_W'(1);
                  state_q    <= S_LO;
                  in_ready_q <= 1'b1;
               end
            end
`ifdef PMEM_LOAD_CHECKSUM_EN
            S_CHK: begin
               if (hs_c) begin
                  in_ready_q <= 1'b0;
                  if (csum_match_c) begin
                     state_q <= S_HOLD;
                     hold_q  <= HOLD_W'(RELEASE_DLY);
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     err_q   <= 1'b1;
                  end
               end
            end
`endif
            S_HOLD: begin
               // Release on the RELEASE_DLY-th cycle in HOLD; <= also covers a zero load.
               if (hold_q <= HOLD_W'(1)) begin
                  hold_q    <= '0;
                  state_q   <= S_RUN;
                  cpu_run_q <= 1'b1;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
               end else begin
                  hold_q <= hold_q - HOLD_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign LEnable  = len_q;
   assign LAddress = laddr_q;
   assign LI_port  = li_q;
   assign cpu_run  = cpu_run_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
